accum_alu: RTL and testbench
============================

Name: accum_alu

Overview:
- Parametrised, registered successor to the top-level combinational 8-bit adder.
- Adds subtraction, an internal accumulator, optional saturation and carry/overflow flags.
- Operands are accepted through a valid/ready handshake. Results leave through a 1-deep output register with backpressure.
- Instantiated inside the TinyTapeout top wrapper: operands come from ui_in/uio_in, results go to uo_out.

Parameters:
- WIDTH, 8: operand, result and accumulator width in bits (legal 2..16).
- SIGNED, 0: 0 means saturation clamps use unsigned limits; 1 means two's-complement limits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  operand/op presented.
- in_ready  output  1  block can accept this cycle.
- op  input  2  operation code: 0 ADD, 1 SUB, 2 ACC, 3 LOAD.
- sat_en  input  1  saturate the result instead of wrapping; sampled with the operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B; ignored for ACC and LOAD.
- out_valid  output  1  result register holds unconsumed data.
- out_ready  input  1  downstream consumes the result.
- result  output  WIDTH  registered result.
- carry  output  1  carry-out (ADD/ACC) or borrow (SUB).
- ovf  output  1  two's-complement signed overflow.
- acc  output  WIDTH  current accumulator value (registered).

Behaviour:
- Reset: when rst_n is sampled low at a clock edge:
  - out_valid, result, carry, ovf and acc all become 0.
  - in_ready is forced 0 while rst_n is low.
  - An in-flight result is discarded. No partial state survives.
- Handshake:
  - in_ready = rst_n && (!out_valid || out_ready), combinational.
  - Accept happens when in_valid && in_ready.
  - Latency is 1: result, flags and out_valid=1 appear on the cycle after the accept edge.
  - Throughput is 1 operation per cycle while out_ready=1.
- Backpressure: while out_valid=1 and out_ready=0, result, carry, ovf and acc hold stable and no input is accepted.
- Drain: if out_ready=1 and there is no accept, out_valid goes to 0 next cycle. result and flags keep their last values.
- Same cycle consume + accept: the register is overwritten with the new result and out_valid stays 1. No bubble, no loss.
- Operations, all on an accept edge; raw results are computed on WIDTH+1 bits:
  - ADD: raw = a + b; result = raw[W-1:0]; carry = raw[W].
  - SUB: raw = a - b; carry = borrow (a < b unsigned).
  - ACC: raw = acc + a; acc and result both take the final (possibly saturated) value.
  - LOAD: acc = a, result = a, carry = 0, ovf = 0.
  - acc changes only on ACC or LOAD accepts.
- ovf: computed for ADD, SUB and ACC as the two's-complement overflow of the wrapped sum, regardless of SIGNED.
- Saturation (sat_en=1), SIGNED=0:
  - ADD/ACC with carry clamps to all-ones.
  - SUB with borrow clamps to 0.
- Saturation (sat_en=1), SIGNED=1:
  - ovf with a positive true result clamps to 0111..1.
  - ovf with a negative true result clamps to 1000..0.
- Flags always report the unsaturated arithmetic, even when the result is clamped.
- Wrap: with sat_en=0 results wrap modulo 2^WIDTH.
- in_valid is low-don't-care: op, a, b and sat_en are ignored when no accept occurs.

Decomposition:
- Package accum_alu_pkg holds:
  - op enum: OP_ADD=0, OP_SUB=1, OP_ACC=2, OP_LOAD=3.
  - op width constant OP_W=2.
- One combinational sub-module, sat_addsub, parametrised by WIDTH/SIGNED:
  - Inputs: x, y, sub, sat_en.
  - Outputs: sum, carry, ovf.
  - Reused for ADD, SUB and ACC, with x muxed between a and acc.
- Top: handshake, output register, accumulator register.

Test Plan:
- Reset: rst_n=0 for 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, acc=0, result=0. After release in_ready=1.
- ADD wrap/saturate (W=8, SIGNED=0): ADD a=200 b=100 sat_en=0 -> result 44, carry 1. Same with sat_en=1 -> result 255, carry 1.
- SUB/signed (SIGNED=1): SUB a=0x80 b=0x01 sat_en=1 -> result 0x80, ovf 1. With sat_en=0 -> result 0x7F, ovf 1, carry 0.
- Accumulate: LOAD a=10, then ACC a=5 three times back-to-back with out_ready=1 -> results 10, 15, 20, 25 on consecutive cycles; acc=25.
- Backpressure: out_ready=0 for 3 cycles after ADD 3+4 -> result 7 held, in_ready=0, pending ACC not accepted and acc unchanged. out_ready=1 with new input the same cycle -> next result appears without a bubble.
- Reset mid-stream: rst_n=0 while out_valid=1 and acc=25 -> next cycle out_valid=0, acc=0; the pending result is never presented.

Source files
------------

// File: rtl/accum_alu_pkg.sv
// Shared types for the accumulating ALU: operation encoding and its width.
// No logic, no latency.
// No flow control.
package accum_alu_pkg;

    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 2'd0,
        OP_SUB  = 2'd1,
        OP_ACC  = 2'd2,
        OP_LOAD = 2'd3
    } op_e;

endpackage

// File: rtl/accum_alu_sat_addsub.sv
// Combinational add/subtract with optional unsigned or two's-complement clamping.
// Latency 0 (pure combinational).
// No flow control; the caller registers the outputs.
module sat_addsub #(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             sub,
    input  logic             sat_en,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH:0] raw;
    logic           same_sign;

    always_comb begin
        raw       = sub ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
        carry     = raw[WIDTH];
        same_sign = (x[WIDTH-1] == y[WIDTH-1]);
        // Overflow: operands effectively share a sign but the wrapped result flips it.
        ovf       = (sub ? !same_sign : same_sign) && (raw[WIDTH-1] != x[WIDTH-1]);
        sum       = raw[WIDTH-1:0];

        // On overflow the true result always carries the sign of x.
        if (sat_en) begin
            if (SIGNED) begin
                if (ovf) begin
                    sum = x[WIDTH-1] ? SMIN : SMAX;
                end
            end else if (carry) begin
                sum = sub ? '0 : '1;
            end
        end
    end

endmodule

// File: rtl/accum_alu.sv
// Registered add/sub/accumulate ALU with valid/ready input and a 1-deep result register.
// Latency 1 cycle from accept to out_valid; throughput 1/cycle while out_ready is high.
// Holds result and acc while out_valid && !out_ready; in_ready drops until consumed.
module accum_alu
    import accum_alu_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic             sat_en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             ovf,
    output logic [WIDTH-1:0] acc
);

    op_e             op_q;
    logic            accept;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] alu_sum;
    logic            alu_carry;
    logic            alu_ovf;

    assign op_q     = op_e'(op);
    assign in_ready = rst_n && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // ACC reuses the adder with the accumulator standing in for operand A.
    assign x = (op_q == OP_ACC) ? acc : a;
    assign y = (op_q == OP_ACC) ? a   : b;

    sat_addsub #(
        .WIDTH  (WIDTH),
        .SIGNED (SIGNED)
    ) u_sat_addsub (
        .x      (x),
        .y      (y),
        .sub    (op_q == OP_SUB),
        .sat_en (sat_en),
        .sum    (alu_sum),
        .carry  (alu_carry),
        .ovf    (alu_ovf)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            carry     <= 1'b0;
            ovf       <= 1'b0;
            acc       <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            case (op_q)
                OP_LOAD: begin
                    result <= a;
                    acc    <= a;
                    carry  <= 1'b0;
                    ovf    <= 1'b0;
                end
                OP_ACC: begin
                    result <= alu_sum;
                    acc    <= alu_sum;
                    carry  <= alu_carry;
                    ovf    <= alu_ovf;
                end
                default: begin
                    result <= alu_sum;
                    carry  <= alu_carry;
                    ovf    <= alu_ovf;
                end
            endcase
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_accum_alu.sv
// Directed bench for accum_alu: one unsigned and one signed instance share stimulus.
module tb_accum_alu;
    import accum_alu_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [1:0]   op;
    logic         sat_en;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_ready;

    logic         u_in_ready, u_out_valid, u_carry, u_ovf;
    logic [W-1:0] u_result, u_acc;
    logic         s_in_ready, s_out_valid, s_carry, s_ovf;
    logic [W-1:0] s_result, s_acc;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    accum_alu #(.WIDTH(W), .SIGNED(1'b0)) dut_u (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(u_in_ready),
        .op(op), .sat_en(sat_en), .a(a), .b(b),
        .out_valid(u_out_valid), .out_ready(out_ready), .result(u_result),
        .carry(u_carry), .ovf(u_ovf), .acc(u_acc)
    );

    accum_alu #(.WIDTH(W), .SIGNED(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .op(op), .sat_en(sat_en), .a(a), .b(b),
        .out_valid(s_out_valid), .out_ready(out_ready), .result(s_result),
        .carry(s_carry), .ovf(s_ovf), .acc(s_acc)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input op_e o, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic s);
        in_valid = 1'b1;
        op       = o;
        a        = va;
        b        = vb;
        sat_en   = s;
    endtask

    task automatic send(input op_e o, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic s);
        drive(o, va, vb, s);
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        drive(OP_ADD, 8'd1, 8'd1, 1'b0);

        // Reset held with in_valid high
        step();
        step();
        chk("rst_in_ready",   u_in_ready,  0);
        chk("rst_s_in_ready", s_in_ready,  0);
        chk("rst_out_valid",  u_out_valid, 0);
        chk("rst_acc",        u_acc,       0);
        chk("rst_result",     u_result,    0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", u_in_ready, 1);
        in_valid = 1'b0;
        step();
        chk("idle_out_valid", u_out_valid, 0);

        // Unsigned ADD wrap and saturate
        send(OP_ADD, 8'd200, 8'd100, 1'b0);
        chk("add_wrap_result", u_result,    44);
        chk("add_wrap_carry",  u_carry,     1);
        chk("add_wrap_ovf",    u_ovf,       0);
        chk("add_wrap_valid",  u_out_valid, 1);
        send(OP_ADD, 8'd200, 8'd100, 1'b1);
        chk("add_sat_result", u_result, 255);
        chk("add_sat_carry",  u_carry,  1);

        // Signed overflow on ADD: unsigned clamp idle, signed clamp to max
        send(OP_ADD, 8'd100, 8'd100, 1'b1);
        chk("add_u_nosat",   u_result, 200);
        chk("add_u_ovf",     u_ovf,    1);
        chk("add_s_sat_pos", s_result, 8'h7F);

        // Unsigned SUB borrow wrap and clamp
        send(OP_SUB, 8'd5, 8'd10, 1'b0);
        chk("sub_wrap_result", u_result, 251);
        chk("sub_wrap_borrow", u_carry,  1);
        send(OP_SUB, 8'd5, 8'd10, 1'b1);
        chk("sub_sat_result", u_result, 0);

        // Signed SUB overflow
        send(OP_SUB, 8'h80, 8'h01, 1'b1);
        chk("sub_s_sat_result", s_result, 8'h80);
        chk("sub_s_sat_ovf",    s_ovf,    1);
        chk("sub_u_nosat",      u_result, 8'h7F);
        send(OP_SUB, 8'h80, 8'h01, 1'b0);
        chk("sub_s_wrap_result", s_result, 8'h7F);
        chk("sub_s_wrap_ovf",    s_ovf,    1);
        chk("sub_s_wrap_carry",  s_carry,  0);
        chk("acc_untouched",     u_acc,    0);

        // LOAD then three back-to-back ACCs
        drive(OP_LOAD, 8'd10, 8'd99, 1'b0);
        step();
        chk("load_result", u_result, 10);
        chk("load_acc",    u_acc,    10);
        drive(OP_ACC, 8'd5, 8'd99, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            chk("acc_in_ready", u_in_ready, 1);
            step();
            chk("acc_result", u_result,    16'(10 + 5 * i));
            chk("acc_valid",  u_out_valid, 1);
        end
        in_valid = 1'b0;
        chk("acc_final",   u_acc, 25);
        chk("acc_s_final", s_acc, 25);

        // Drain: valid falls, result held
        step();
        chk("drain_valid",  u_out_valid, 0);
        chk("drain_result", u_result,    25);

        // Backpressure: ADD 3+4 held while a pending ACC waits
        out_ready = 1'b0;
        send(OP_ADD, 8'd3, 8'd4, 1'b0);
        chk("bp_result", u_result, 7);
        drive(OP_ACC, 8'd9, 8'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", u_in_ready, 0);
            step();
            chk("bp_hold_result", u_result,    7);
            chk("bp_hold_valid",  u_out_valid, 1);
            chk("bp_hold_acc",    u_acc,       25);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", u_in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("bp_next_result", u_result,    34);
        chk("bp_next_acc",    u_acc,       34);
        chk("bp_next_valid",  u_out_valid, 1);
        chk("bp_s_valid",     s_out_valid, 1);

        // Reset mid-stream with a pending result
        drive(OP_LOAD, 8'd25, 8'd0, 1'b0);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("pre_rst_acc",   u_acc,       25);
        chk("pre_rst_valid", u_out_valid, 1);
        rst_n = 1'b0;
        step();
        chk("mid_rst_valid",  u_out_valid, 0);
        chk("mid_rst_acc",    u_acc,       0);
        chk("mid_rst_result", u_result,    0);
        chk("mid_rst_carry",  u_carry,     0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();
        chk("after_rst_valid", u_out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
